// File: rtl/snake_pkg.sv
// Direction codes and helpers shared by the direction controller and the game logic.
// A direction is a 3-bit code; DIR_IDLE marks "game not started yet".
package snake_pkg;

  typedef logic [2:0] dir_t;

  localparam dir_t DIR_UP    = 3'd1;
  localparam dir_t DIR_RIGHT = 3'd2;
  localparam dir_t DIR_DOWN  = 3'd3;
  localparam dir_t DIR_LEFT  = 3'd4;
  localparam dir_t DIR_IDLE  = 3'd5;

  localparam int NUM_BTN = 4;
  localparam int QDEPTH  = 2;

  function automatic logic is_move_dir(input dir_t d);
    return (d >= DIR_UP) && (d <= DIR_LEFT);
  endfunction

  // Opposite directions have codes two apart. Idle is never opposite to anything.
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    if (!is_move_dir(a) || !is_move_dir(b)) begin
      return 1'b0;
    end
    return (a > b) ? ((a - b) == 3'd2) : ((b - a) == 3'd2);
  endfunction

  // Button index 0..3 (up, right, down, left) maps onto codes 1..4.
  function automatic dir_t btn_to_dir(input int idx);
    return dir_t'(idx + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, stability counter and rising-edge press pulse.
// level follows the synchronized input only after DEBOUNCE_CYCLES consecutive differing cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any cycle where the synchronized level agrees with level_q restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Turns four debounced direction buttons into a 2-deep queue of legal turns,
// popped into the current direction on each game tick.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       up,
  input  logic       right,
  input  logic       down,
  input  logic       left,
  input  logic       tick,
  output logic [2:0] move,
  output logic [1:0] qcount,
  output logic       drop
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] press_vld;

  assign btn_raw = {left, down, right, up};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock (clock),
      .resetn(resetn),
      .btn   (btn_raw[gi]),
      .level (btn_level[gi]),
      .press (btn_press[gi])
    );
  end

  // A press only counts while its debounced level still reads pressed.
  assign press_vld = btn_press & btn_level;

  dir_t       move_q,  move_d;
  dir_t       slot0_q, slot0_d;
  dir_t       slot1_q, slot1_d;
  logic [1:0] cnt_q,   cnt_d;
  logic       drop_q,  drop_d;

  dir_t win_dir;
  dir_t tail_dir;
  dir_t ref_dir;
  logic any_press;
  logic multi_press;
  logic accept;
  logic full;
  logic pop;
  logic push;

  // Lowest index wins, giving up > right > down > left.
  always_comb begin
    win_dir = DIR_IDLE;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (press_vld[i]) begin
        win_dir = btn_to_dir(i);
      end
    end
  end

  assign any_press   = |press_vld;
  assign multi_press = (press_vld & (press_vld - NUM_BTN'(1))) != '0;
  assign full        = (cnt_q == 2'(QDEPTH));
  assign tail_dir    = full ? slot1_q : slot0_q;
  assign ref_dir     = (cnt_q == 2'd0) ? move_q : tail_dir;
  assign accept      = any_press &&
                       ((ref_dir == DIR_IDLE) ||
                        ((win_dir != ref_dir) && !is_opposite(win_dir, ref_dir)));
  assign pop         = tick && (cnt_q != 2'd0);
  assign push        = accept && (!full || tick);

  always_comb begin
    move_d  = move_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;

    if (multi_press || (any_press && !accept) || (accept && !push)) begin
      drop_d = 1'b1;
    end

    if (pop) begin
      move_d = slot0_q;
    end

    // slot0 is always the head; a simultaneous pop and push shifts and appends.
    case ({pop, push})
      2'b10: begin
        slot0_d = slot1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd0) begin
          slot0_d = win_dir;
        end else begin
          slot1_d = win_dir;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        if (full) begin
          slot0_d = slot1_q;
          slot1_d = win_dir;
        end else begin
          slot0_d = win_dir;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      move_q  <= DIR_IDLE;
      slot0_q <= DIR_IDLE;
      slot1_q <= DIR_IDLE;
      cnt_q   <= 2'd0;
      drop_q  <= 1'b0;
    end else begin
      move_q  <= move_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign move   = move_q;
  assign qcount = cnt_q;
  assign drop   = drop_q;

endmodule

// File: doc/snake_dir_ctrl.md
SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required before a button change is accepted (10 ms at 50 MHz).
REQ-002 Port: clock  in  1  single system clock; all logic on its rising edge.
REQ-003 Port: resetn  in  1  reset, synchronous and active-low.
REQ-004 Port: up, right, down, left  in  1 each  raw asynchronous push-button levels, 1 = pressed.
REQ-005 Port: tick  in  1  one-cycle game-step strobe from the game logic; pops one queued turn.
REQ-006 Port: move  out  3  current direction: 1=up, 2=right, 3=down, 4=left, 5=idle (not started).
REQ-007 Port: qcount  out  2  number of pending turns in the queue (0..2).
REQ-008 Port: drop  out  1  one-cycle pulse when a press is discarded.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 A per-button counter SHALL update the debounced level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the debounced value clears the counter.
REQ-011 A press SHALL be a one-cycle pulse on the 0->1 edge of the debounced level; release generates nothing.
REQ-012 Multiple presses in the same cycle: priority up > right > down > left; the winner is processed, and drop pulses once for the losers.
REQ-013 Reference direction: the queue tail if qcount>0, otherwise move.
REQ-014 Press accepted only if reference is 5 (idle), or the pressed direction is neither equal nor opposite to the reference (opposite = codes differing by 2); rejected presses pulse drop.
REQ-015 Accepted presses SHALL enter a 2-entry FIFO; a press arriving while full and without a simultaneous tick pulses drop, and the queue is unchanged.
REQ-016 On tick with qcount>0: move <= head and pop; on tick with qcount=0: move holds.
REQ-017 Tick and accepted press in the same cycle: pop and push both occur; the reference for REQ-014 is taken before the pop; a full queue accepts the push; qcount is unchanged.
REQ-018 Tick and press with queue empty: the press is enqueued, but move is not updated until the next tick (no bypass).
REQ-019 Latency: debounced edge -> enqueue visible on qcount 1 cycle later; queue head -> move 1 cycle after tick.
REQ-020 move, qcount, drop SHALL be registered outputs.

Reset
REQ-021 While resetn=0 at a clock edge: move=5, qcount=0, drop=0, FIFO emptied, synchronizers, counters and debounced levels = 0.
REQ-022 Reset applied mid-operation SHALL discard pending turns and partial debounce counts without emitting drop.
REQ-023 A button held through reset release SHALL produce a press after DEBOUNCE_CYCLES+2 cycles.

Structure
REQ-024 Shared package snake_pkg SHALL hold the direction codes DIR_UP=1, DIR_RIGHT=2, DIR_DOWN=3, DIR_LEFT=4, DIR_IDLE=5, the 3-bit direction type, and an is_opposite function; the game logic imports the same package.
REQ-025 One sub-module btn_debounce (synchronizer + counter + edge detect, parameter DEBOUNCE_CYCLES, outputs level and press pulse) SHALL be instantiated four times; the FIFO and arbitration live in snake_dir_ctrl.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 From reset, hold right for 10 cycles, then pulse tick -> qcount=1 at cycle 7, move=2 one cycle after tick, qcount=0.
REQ-027 Bounce: toggle up every 2 cycles for 20 cycles, then release -> no press, qcount=0, drop never asserted.
REQ-028 move=2, qcount=0; press left -> drop pulse, qcount stays 0; then press up, then down -> up queued, down rejected (opposite of tail up) with drop.
REQ-029 move=1, queue holds {2,3}; press left with no tick -> drop, qcount=2; repeat with tick in the same cycle -> move=2, queue {3,4}, qcount=2, no drop.
REQ-030 Up and left debounced-rise in the same cycle from idle -> up enqueued, single drop pulse.
REQ-031 Queue holds 2 entries, assert resetn=0 for 1 cycle -> move=5, qcount=0, drop=0; next tick leaves move=5.
